// File: rtl/trap_pkg.sv
// Shared types and constants for the trap entry/exit sequencer.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_HANDLER,
        ST_HALT
    } state_t;

    localparam int unsigned CAUSE_W  = 3;
    localparam int unsigned TRAPNR_W = 4;
    localparam int unsigned STATS_W  = 16;

    localparam logic [CAUSE_W-1:0] TRAP_PROT   = 3'd0;
    localparam logic [CAUSE_W-1:0] TRAP_PAGE   = 3'd1;
    localparam logic [CAUSE_W-1:0] TRAP_UART   = 3'd2;
    localparam logic [CAUSE_W-1:0] TRAP_TIMER  = 3'd3;
    localparam logic [CAUSE_W-1:0] TRAP_DOUBLE = 3'd4;

    localparam logic [15:0]  VEC_BASE_DEF  = 16'h0010;
    localparam int unsigned  VEC_SHIFT_DEF = 2;

endpackage

// File: rtl/trap_cause_enc.sv
// Lowest-set-bit encoder: 4-bit trap mask to 3-bit cause index (0 when mask is empty).
module trap_cause_enc
    import trap_pkg::*;
(
    input  logic [TRAPNR_W-1:0] mask,
    output logic [CAUSE_W-1:0]  idx_c
);

    always_comb begin
        idx_c = TRAP_PROT;
        if (mask[0]) begin
            idx_c = TRAP_PROT;
        end else if (mask[1]) begin
            idx_c = TRAP_PAGE;
        end else if (mask[2]) begin
            idx_c = TRAP_UART;
        end else if (mask[3]) begin
            idx_c = TRAP_TIMER;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: safe-point selection, EPC/cause capture, vectoring, reti, double-fault halt.
// Optional build macro TRAP_STATS_EN adds a saturating trap_count output.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned     PC_W      = 16,
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(VEC_BASE_DEF),
    parameter int unsigned     VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                irq,
    input  logic                fault,
    input  logic [TRAPNR_W-1:0] trapnr,
    input  logic                instr_done,
    input  logic [PC_W-1:0]     pc_in,
    input  logic                reti,
    input  logic                ie_set,
    input  logic                ie_clr,
    output logic                deassert,
    output logic                flush,
    output logic                redirect,
    output logic [PC_W-1:0]     redirect_pc,
    output logic [PC_W-1:0]     epc,
    output logic [CAUSE_W-1:0]  cause,
    output logic                ie,
    output logic                in_trap,
    output logic                halted
`ifdef TRAP_STATS_EN
    ,
    output logic [STATS_W-1:0]  trap_count
`endif
);

    state_t              state, state_n;
    logic                pie, pie_n;
    logic                deassert_n, flush_n, redirect_n;
    logic [PC_W-1:0]     redirect_pc_n, epc_n;
    logic [CAUSE_W-1:0]  cause_n, enc_idx;
    logic                ie_n, in_trap_n, halted_n;

    function automatic logic [PC_W-1:0] vec_addr(input logic [CAUSE_W-1:0] idx);
        return VEC_BASE + (PC_W'(idx) << VEC_SHIFT);
    endfunction

    trap_cause_enc u_cause_enc (
        .mask  (trapnr),
        .idx_c (enc_idx)
    );

    // Outputs are registered: each state's strobes are computed one cycle early from the next state.
    always_comb begin
        state_n       = state;
        deassert_n    = 1'b0;
        flush_n       = 1'b0;
        redirect_n    = 1'b0;
        redirect_pc_n = redirect_pc;
        epc_n         = epc;
        cause_n       = cause;
        ie_n          = ie;
        pie_n         = pie;
        in_trap_n     = in_trap;
        halted_n      = halted;

        case (state)
            ST_IDLE: begin
                if (ie_clr) begin
                    ie_n = 1'b0;
                end else if (ie_set) begin
                    ie_n = 1'b1;
                end
                if (fault || (irq && ie && instr_done)) begin
                    state_n = ST_SAVE;
                    flush_n = 1'b1;
                end
            end
            ST_SAVE: begin
                epc_n         = pc_in;
                cause_n       = enc_idx;
                pie_n         = ie;
                ie_n          = 1'b0;
                in_trap_n     = 1'b1;
                redirect_n    = 1'b1;
                deassert_n    = 1'b1;
                redirect_pc_n = vec_addr(enc_idx);
                state_n       = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_n = ST_HANDLER;
            end
            ST_HANDLER: begin
                // Handler-level enable writes go to pie so that reti restores them.
                if (ie_clr) begin
                    pie_n = 1'b0;
                end else if (ie_set) begin
                    pie_n = 1'b1;
                end
                if (fault) begin
                    cause_n       = TRAP_DOUBLE;
                    redirect_n    = 1'b1;
                    redirect_pc_n = vec_addr(TRAP_DOUBLE);
                    halted_n      = 1'b1;
                    state_n       = ST_HALT;
                end else if (reti) begin
                    redirect_n    = 1'b1;
                    redirect_pc_n = epc;
                    ie_n          = pie_n;
                    in_trap_n     = 1'b0;
                    state_n       = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            deassert    <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            epc         <= '0;
            cause       <= '0;
            ie          <= 1'b0;
            pie         <= 1'b0;
            in_trap     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            deassert    <= deassert_n;
            flush       <= flush_n;
            redirect    <= redirect_n;
            redirect_pc <= redirect_pc_n;
            epc         <= epc_n;
            cause       <= cause_n;
            ie          <= ie_n;
            pie         <= pie_n;
            in_trap     <= in_trap_n;
            halted      <= halted_n;
        end
    end

`ifdef TRAP_STATS_EN
    // Counts trap entries (one per SAVE cycle), saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_count <= '0;
        end else if ((state == ST_SAVE) && (trap_count != '1)) begin
            trap_count <= trap_count + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus queues expected redirects, a negedge monitor checks them.
module tb_trap_sequencer;
    import trap_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] epc;
        logic [2:0]  cause;
        logic        ie;
        logic        in_trap;
        logic        halted;
        logic        entry;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq = 1'b0;
    logic        fault = 1'b0;
    logic [3:0]  trapnr = 4'h0;
    logic        instr_done = 1'b0;
    logic [15:0] pc_in = 16'h0;
    logic        reti = 1'b0;
    logic        ie_set = 1'b0;
    logic        ie_clr = 1'b0;
    logic        deassert, flush, redirect;
    logic [15:0] redirect_pc, epc;
    logic [2:0]  cause;
    logic        ie, in_trap, halted;
`ifdef TRAP_STATS_EN
    logic [15:0] trap_count;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_flush = 1'b0;
    logic prev_redirect = 1'b0;

    trap_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .fault       (fault),
        .trapnr      (trapnr),
        .instr_done  (instr_done),
        .pc_in       (pc_in),
        .reti        (reti),
        .ie_set      (ie_set),
        .ie_clr      (ie_clr),
        .deassert    (deassert),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .epc         (epc),
        .cause       (cause),
        .ie          (ie),
        .in_trap     (in_trap),
        .halted      (halted)
`ifdef TRAP_STATS_EN
        ,
        .trap_count  (trap_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending redirects expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic entry(input logic use_fault, input logic [3:0] tn, input logic [15:0] pc,
                         input logic [15:0] vpc, input logic [2:0] c);
        exp_t e;
        e.pc = vpc; e.epc = pc; e.cause = c; e.ie = 1'b0; e.in_trap = 1'b1;
        e.halted = 1'b0; e.entry = 1'b1; e.cyc = cyc + 2;
        sb.push_back(e);
        fault = use_fault; irq = !use_fault; instr_done = !use_fault;
        trapnr = tn; pc_in = pc;
        tick();
        tick();
        fault = 1'b0; irq = 1'b0; instr_done = 1'b0; trapnr = 4'h0;
        wait_drain("entry");
    endtask

    task automatic ret(input logic [15:0] pc, input logic [2:0] c, input logic exp_ie);
        exp_t e;
        e.pc = pc; e.epc = pc; e.cause = c; e.ie = exp_ie; e.in_trap = 1'b0;
        e.halted = 1'b0; e.entry = 1'b0; e.cyc = cyc + 1;
        sb.push_back(e);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        wait_drain("reti");
    endtask

    // Monitor: every redirect strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (redirect) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_redirect: got redirect_pc=%0h expected no redirect", redirect_pc);
            end else begin
                e = sb.pop_front();
                chk("redirect_pc", redirect_pc, e.pc);
                chk("epc", epc, e.epc);
                chk("cause", 16'(cause), 16'(e.cause));
                chk("ie", 16'(ie), 16'(e.ie));
                chk("in_trap", 16'(in_trap), 16'(e.in_trap));
                chk("halted", 16'(halted), 16'(e.halted));
                chk("deassert", 16'(deassert), 16'(e.entry));
                chk("latency_cycle", 16'(cyc), 16'(e.cyc));
                if (e.entry) chk("flush_before_redirect", 16'(prev_flush), 16'h1);
            end
            chk("redirect_width", 16'(prev_redirect), 16'h0);
        end else if (deassert) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_deassert: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (flush) chk("flush_width", 16'(prev_flush), 16'h0);
        prev_flush = flush;
        prev_redirect = redirect;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;

        // Reset state
        tick(); tick(); tick();
        chk("rst_redirect_pc", redirect_pc, 16'h0);
        chk("rst_epc", epc, 16'h0);
        chk("rst_cause", 16'(cause), 16'h0);
        chk("rst_flags", 16'({ie, in_trap, halted, flush, redirect, deassert}), 16'h0);
        reset = 1'b0;
        tick();

        // ie_set in IDLE, then timer irq entry
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        chk("ie_after_set", 16'(ie), 16'h1);
        entry(1'b0, 4'b1000, 16'h0100, 16'h001C, 3'd3);

        // reti restores ie=1; then set+clr together clears
        ret(16'h0100, 3'd3, 1'b1);
        ie_set = 1'b1; ie_clr = 1'b1; tick(); ie_set = 1'b0; ie_clr = 1'b0;
        chk("ie_clr_wins", 16'(ie), 16'h0);

        // Masked uart irq held for 10 cycles
        npulse = 0;
        irq = 1'b1; instr_done = 1'b1; trapnr = 4'b0100; pc_in = 16'h0180;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (flush || redirect || deassert) npulse++;
        end
        irq = 1'b0; instr_done = 1'b0; trapnr = 4'h0;
        chk("masked_irq_pulses", 16'(npulse), 16'h0);
        chk("masked_irq_in_trap", 16'(in_trap), 16'h0);

        // Fault entry without instr_done or ie
        entry(1'b1, 4'b0010, 16'h0234, 16'h0014, 3'd1);

        // Handler ie_set writes pie only; reti then restores it
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        chk("handler_ie_unchanged", 16'(ie), 16'h0);
        ret(16'h0234, 3'd1, 1'b1);

        // Timer entry, then fault+reti together -> double fault
        entry(1'b0, 4'b1000, 16'h0300, 16'h001C, 3'd3);
        begin
            exp_t e;
            e.pc = 16'h0020; e.epc = 16'h0300; e.cause = 3'd4; e.ie = 1'b0;
            e.in_trap = 1'b1; e.halted = 1'b1; e.entry = 1'b0; e.cyc = cyc + 1;
            sb.push_back(e);
        end
        fault = 1'b1; reti = 1'b1; tick(); fault = 1'b0; reti = 1'b0;
        wait_drain("double_fault");

        // HALT absorbs irq, fault and reti
        npulse = 0;
        irq = 1'b1; fault = 1'b1; reti = 1'b1; instr_done = 1'b1; trapnr = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (flush || redirect || deassert) npulse++;
        end
        irq = 1'b0; fault = 1'b0; reti = 1'b0; instr_done = 1'b0; trapnr = 4'h0;
        chk("halt_pulses", 16'(npulse), 16'h0);
        chk("halt_sticky", 16'(halted), 16'h1);
        chk("halt_cause", 16'(cause), 16'h4);

        // Reset out of HALT, then reset asserted during VECTOR
        reset = 1'b1; tick(); reset = 1'b0;
        chk("halt_reset_halted", 16'(halted), 16'h0);
        begin
            exp_t e;
            e.pc = 16'h0010; e.epc = 16'h0400; e.cause = 3'd0; e.ie = 1'b0;
            e.in_trap = 1'b1; e.halted = 1'b0; e.entry = 1'b1; e.cyc = cyc + 2;
            sb.push_back(e);
        end
        fault = 1'b1; trapnr = 4'b0001; pc_in = 16'h0400;
        tick(); tick();
        fault = 1'b0; trapnr = 4'h0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("vec_reset_pulses", 16'({flush, redirect, deassert}), 16'h0);
        chk("vec_reset_epc", epc, 16'h0);
        chk("vec_reset_redirect_pc", redirect_pc, 16'h0);
        chk("vec_reset_flags", 16'({cause, ie, in_trap, halted}), 16'h0);
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush || redirect || deassert) npulse++;
        end
        chk("post_reset_pulses", 16'(npulse), 16'h0);

        // Three entries after reset (ie=0, so fault-driven)
        entry(1'b1, 4'b0100, 16'h0500, 16'h0018, 3'd2);
        ret(16'h0500, 3'd2, 1'b0);
        entry(1'b1, 4'b0000, 16'h0600, 16'h0010, 3'd0);
        ret(16'h0600, 3'd0, 1'b0);
        entry(1'b1, 4'b1100, 16'hFFF0, 16'h0018, 3'd2);
        ret(16'hFFF0, 3'd2, 1'b0);
`ifdef TRAP_STATS_EN
        chk("trap_count", trap_count, 16'd3);
`endif

        tick(); tick();
        chk("sb_empty", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Downstream consumer of the interrupt/fault priority encoder. Takes its `irq`, `fault` and `trapnr` outputs and sequences trap entry for the CPU core.
- Entry: picks a safe point, captures EPC/cause, clears global interrupt enable, redirects fetch to the vector, and pulses `deassert` back to the encoder.
- Exit: handles return-from-trap (`reti`).
- A fault taken while already in a handler is a double fault and halts the core.

Parameters:
- PC_W, 16, width of PC, EPC, vector and redirect address.
- VEC_BASE, 16'h0010, address of vector slot 0.
- VEC_SHIFT, 2, log2 of vector slot stride in words; slot n is at VEC_BASE + (n << VEC_SHIFT).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- irq  in  1  maskable interrupt pending, from encoder.
- fault  in  1  fault pending, from encoder.
- trapnr  in  4  one-hot-ish trap mask from encoder: bit0 prot, bit1 page, bit2 uart, bit3 timer.
- instr_done  in  1  core at instruction boundary this cycle.
- pc_in  in  PC_W  PC of the current instruction (fault) or next instruction (irq).
- reti  in  1  core retiring a return-from-trap this cycle.
- ie_set  in  1  enable-interrupts instruction retiring.
- ie_clr  in  1  disable-interrupts instruction retiring.
- deassert  out  1  one-cycle acknowledge to encoder.
- flush  out  1  one-cycle pipeline kill.
- redirect  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  PC_W  target, valid when redirect=1.
- epc  out  PC_W  saved return PC.
- cause  out  3  index of trap taken (0..3; 4 = double fault).
- ie  out  1  global interrupt enable.
- in_trap  out  1  handler active.
- halted  out  1  sticky double-fault halt.

Behaviour:
- Reset values (synchronous, highest priority, valid from any state including mid-sequence):
  - state=IDLE; all outputs 0; ie=0; pie=0.
  - No deassert or redirect is emitted on the reset cycle.
- States: IDLE, SAVE, VECTOR, HANDLER, HALT.
- IDLE:
  - fault=1 → SAVE next cycle, regardless of instr_done or ie.
  - Else irq=1 & ie=1 & instr_done=1 → SAVE.
  - Else stay.
- SAVE (1 cycle):
  - epc<=pc_in; cause<=index of lowest set trapnr bit (0 if trapnr=0).
  - pie<=ie; ie<=0; in_trap<=1; flush=1 this cycle.
- VECTOR (1 cycle):
  - redirect=1; redirect_pc=VEC_BASE+(cause<<VEC_SHIFT); deassert=1.
  - Next state is HANDLER.
- HANDLER:
  - fault=1 → cause<=4, redirect to slot 4, halted<=1, then HALT. Fault beats a simultaneous reti.
  - Else reti=1 → redirect=1, redirect_pc=epc, ie<=pie, in_trap<=0, IDLE.
  - irq is ignored while in HANDLER.
- HALT: absorbing; only reset leaves it. halted=1, no further redirects.
- Total entry latency: redirect is asserted 2 cycles after the qualifying IDLE cycle.
- ie updates:
  - ie_set/ie_clr are honoured only in IDLE and HANDLER.
  - If both are asserted, clr wins.
  - In HANDLER they write pie, not ie, so reti restores the handler-written value.
- Pulses: deassert, flush and redirect are never asserted for more than one consecutive cycle.
- Vector arithmetic is PC_W bits, modulo 2^PC_W, with no overflow flag.

Optional Feature:
- Macro: TRAP_STATS_EN.
- Defined:
  - Adds output `trap_count` (16 bits).
  - Increments by 1 in each SAVE cycle and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package trap_pkg:
  - state enum.
  - trap index constants TRAP_PROT=0, TRAP_PAGE=1, TRAP_UART=2, TRAP_TIMER=3, TRAP_DOUBLE=4.
  - Defaults for VEC_BASE and VEC_SHIFT.
- One natural sub-module, trap_cause_enc: combinational lowest-set-bit encoder from 4-bit mask to 3-bit index.

Test Plan:
- Reset, ie_set in IDLE, timer irq (trapnr=4'b1000) with instr_done=1, pc_in=16'h0100 → flush 1 cycle later; redirect_pc=16'h001C and deassert 2 cycles later; epc=16'h0100; cause=3; ie=0; in_trap=1.
- ie=0 and uart irq held for 10 cycles → no flush, redirect or deassert; state stays IDLE.
- Fault with trapnr=4'b0010, instr_done=0, pc_in=16'h0234 → entry still taken; redirect_pc=16'h0014; epc=16'h0234; cause=1.
- In HANDLER, reti → redirect_pc=epc; in_trap=0; ie restored to 1. Then ie_set and ie_clr together in IDLE → ie=0.
- In HANDLER, fault and reti asserted in the same cycle → redirect_pc=16'h0020, cause=4, halted=1. Later irq, fault and reti have no effect until reset.
- Reset asserted in VECTOR → next cycle all outputs 0; no redirect or deassert pulse seen. With TRAP_STATS_EN defined, three entries → trap_count=3.
